// File: rtl/coin_run_stats_if.sv
// rtl/coin_run_stats_if.sv - report handshake bundle for coin_run_stats
interface coin_run_stats_if #(
  parameter int CW = 8
);
  logic          report_valid;
  logic          report_ready;
  logic [CW-1:0] report_events;
  logic [CW-1:0] report_longest;
  logic          report_overrun;

  modport master (
    output report_valid,
    output report_events,
    output report_longest,
    output report_overrun,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_events,
    input  report_longest,
    input  report_overrun,
    output report_ready
  );
endinterface

// File: rtl/coin_run_stats.sv
// rtl/coin_run_stats.sv - per-window streak event count and longest head run, reported on valid/ready
module coin_run_stats #(
  parameter int WINDOW = 64,
  parameter int CW     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sequence_in,
  input  logic               detector_out,
  coin_run_stats_if.master   rpt
);
  localparam int            TW   = $clog2(WINDOW);
  localparam logic [TW-1:0] LAST = TW'(WINDOW - 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] toss_cnt_q, toss_cnt_d;
  logic [CW-1:0] ev_cnt_q, ev_cnt_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic [CW-1:0] max_run_q, max_run_d;
  logic          det_q, det_d;
  logic [CW-1:0] rep_events_q, rep_events_d;
  logic [CW-1:0] rep_longest_q, rep_longest_d;
  logic          overrun_q, overrun_d;

  logic          win_close;
  logic          load_report;
  logic [CW-1:0] run_nxt;
  logic [CW-1:0] max_nxt;
  logic [CW-1:0] ev_nxt;

  // Window statistics including this cycle's toss, plus report capture and overrun.
  always_comb begin
    win_close   = (toss_cnt_q == LAST);
    run_nxt     = sequence_in ? ((run_cnt_q == CMAX) ? CMAX : run_cnt_q + CW'(1)) : '0;
    max_nxt     = (run_nxt > max_run_q) ? run_nxt : max_run_q;
    ev_nxt      = (detector_out && !det_q && ev_cnt_q != CMAX) ? ev_cnt_q + CW'(1) : ev_cnt_q;
    load_report = win_close && ((state_q == EMPTY) || rpt.report_ready);

    det_d         = detector_out;
    toss_cnt_d    = win_close ? '0 : toss_cnt_q + TW'(1);
    run_cnt_d     = win_close ? '0 : run_nxt;
    max_run_d     = win_close ? '0 : max_nxt;
    ev_cnt_d      = win_close ? '0 : ev_nxt;
    rep_events_d  = load_report ? ev_nxt  : rep_events_q;
    rep_longest_d = load_report ? max_nxt : rep_longest_q;
    overrun_d     = overrun_q || (win_close && (state_q == FULL) && !rpt.report_ready);
  end

  // Report FSM next state: a close fills it, an accept drains it unless a close refills it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (win_close) state_d = FULL;
      FULL:  if (rpt.report_ready && !win_close) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Outputs come straight from registers so nothing combinational reaches the port.
  always_comb begin
    rpt.report_valid   = (state_q == FULL);
    rpt.report_events  = rep_events_q;
    rpt.report_longest = rep_longest_q;
    rpt.report_overrun = overrun_q;
  end

  // Report FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Datapath registers; reset discards the partial window, held report and overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      toss_cnt_q    <= '0;
      ev_cnt_q      <= '0;
      run_cnt_q     <= '0;
      max_run_q     <= '0;
      det_q         <= 1'b0;
      rep_events_q  <= '0;
      rep_longest_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      toss_cnt_q    <= toss_cnt_d;
      ev_cnt_q      <= ev_cnt_d;
      run_cnt_q     <= run_cnt_d;
      max_run_q     <= max_run_d;
      det_q         <= det_d;
      rep_events_q  <= rep_events_d;
      rep_longest_q <= rep_longest_d;
      overrun_q     <= overrun_d;
    end
  end
endmodule

// File: tb/tb_coin_run_stats.sv
// tb/tb_coin_run_stats.sv - directed self-checking bench for coin_run_stats
module tb_coin_run_stats;
  logic clock = 1'b0;
  logic reset;
  logic sequence_in;
  logic detector_out;
  logic report_ready;
  logic [1:0]  hcnt;
  logic [15:0] basic;
  int n_pass;
  int n_total;

  always #5 clock = ~clock;

  coin_run_stats_if #(.CW(8)) rpt_a ();
  coin_run_stats_if #(.CW(4)) rpt_b ();

  assign rpt_a.report_ready = report_ready;
  assign rpt_b.report_ready = report_ready;

  coin_run_stats #(.WINDOW(16), .CW(8)) dut_a (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .detector_out (detector_out),
    .rpt          (rpt_a)
  );

  coin_run_stats #(.WINDOW(32), .CW(4)) dut_b (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .detector_out (detector_out),
    .rpt          (rpt_b)
  );

  // Three-heads Moore detector feeding detector_out.
  always @(posedge clock) begin
    if (reset || !sequence_in) hcnt <= 2'd0;
    else if (hcnt != 2'd3)     hcnt <= hcnt + 2'd1;
  end
  assign detector_out = (hcnt == 2'd3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input logic s, input logic r);
    sequence_in  = s;
    report_ready = r;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    sequence_in  = 1'b0;
    report_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic chk_a(input string tag, input int v, input int ev, input int lg, input int ov);
    chk({tag, "_valid"},   32'(rpt_a.report_valid),   v);
    chk({tag, "_events"},  32'(rpt_a.report_events),  ev);
    chk({tag, "_longest"}, 32'(rpt_a.report_longest), lg);
    chk({tag, "_overrun"}, 32'(rpt_a.report_overrun), ov);
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    basic        = 16'h07DE;
    reset        = 1'b1;
    sequence_in  = 1'b0;
    report_ready = 1'b0;
    @(negedge clock);

    // Basic window
    do_reset();
    chk_a("reset", 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(basic[i], 1'b0);
      if (i == 14) chk("basic_valid_c15", 32'(rpt_a.report_valid), 0);
    end
    chk_a("basic", 1, 2, 5, 0);

    // Back-to-back windows, ready tied high, all heads
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    chk_a("b2b_w1", 1, 1, 16, 0);
    step(1'b1, 1'b1);
    chk("b2b_valid_c17", 32'(rpt_a.report_valid), 0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    chk_a("b2b_w2", 1, 0, 16, 0);

    // Accept coincides with window-2 close
    do_reset();
    for (int i = 0; i < 16; i++) step(basic[i], 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    chk_a("simul_held", 1, 2, 5, 0);
    step(1'b1, 1'b1);
    chk_a("simul_w2", 1, 1, 16, 0);

    // Backpressure and overrun
    do_reset();
    for (int i = 0; i < 16; i++) step(basic[i], 1'b0);
    chk_a("bp_w1", 1, 2, 5, 0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    chk("bp_overrun_c31", 32'(rpt_a.report_overrun), 0);
    step(1'b1, 1'b0);
    chk_a("bp_c32", 1, 2, 5, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    chk_a("bp_c40", 1, 2, 5, 1);
    step(1'b0, 1'b1);
    chk("bp_valid_after_xfer", 32'(rpt_a.report_valid), 0);
    chk("bp_overrun_sticky", 32'(rpt_a.report_overrun), 1);

    // Reset mid-window discards everything
    do_reset();
    chk("rst_overrun_clear", 32'(rpt_a.report_overrun), 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    do_reset();
    chk_a("mid_reset", 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(basic[i], 1'b0);
      if (i < 15) chk("mid_valid_low", 32'(rpt_a.report_valid), 0);
    end
    chk_a("mid_basic", 1, 2, 5, 0);

    // Saturation on the CW=4, WINDOW=32 instance
    do_reset();
    for (int i = 0; i < 31; i++) step(1'b1, 1'b0);
    chk("sat_valid_c31", 32'(rpt_b.report_valid), 0);
    step(1'b1, 1'b0);
    chk("sat_valid", 32'(rpt_b.report_valid), 1);
    chk("sat_longest", 32'(rpt_b.report_longest), 15);
    chk("sat_events", 32'(rpt_b.report_events), 1);
    chk("sat_overrun", 32'(rpt_b.report_overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
